// File: rtl/psum_accum_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_accum_buffer_if
// Purpose  : Valid/ready stream bundle used for both the partial-sum input
//            and the completed-sum output of psum_accum_buffer.
// Signals  : valid - producer has data this cycle
//            ready - consumer takes data this cycle
//            data  - DATA_WIDTH payload
// Modports : master drives valid/data, slave drives ready.
// Revision : 1.0 - initial release
// ============================================================================
interface psum_accum_buffer_if #(
  parameter int DATA_WIDTH = 18
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/psum_accum_buffer.sv
`default_nettype none
// ============================================================================
// Module   : psum_accum_buffer
// Purpose  : Accumulates a row of partial sums across NUM_PASS passes in a
//            scratchpad and streams completed sums out through a
//            first-word-fall-through FIFO.
// Ports    : clk            - clock, rising edge
//            rst            - synchronous active-high reset
//            start_i        - begin a job (honoured only when idle)
//            cfg_row_len_i  - output positions per row, 1..ROW_MAX
//            cfg_num_pass_i - passes to accumulate, >= 1
//            psum_i         - slave stream of incoming partial sums
//            out_o          - master stream of completed sums (FWFT head)
//            busy_o         - a job is in progress
//            done_o         - one-cycle pulse when the job has drained
// Revision : 1.0 - initial release
// ============================================================================
module psum_accum_buffer #(
  parameter int DATA_WIDTH = 18,
  parameter int ROW_MAX    = 32,
  parameter int PASS_W     = 8,
  parameter int OUT_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [$clog2(ROW_MAX):0]  cfg_row_len_i,
  input  logic [PASS_W-1:0]         cfg_num_pass_i,
  psum_accum_buffer_if.slave        psum_i,
  psum_accum_buffer_if.master       out_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int c_POS_W = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
  localparam int c_ROW_W = $clog2(ROW_MAX) + 1;
  localparam int c_PTR_W = $clog2(OUT_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ACCUM = 2'd1;
  localparam logic [1:0] c_ST_FLUSH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [c_POS_W-1:0]    pos_q, pos_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [c_ROW_W-1:0]    row_len_q, row_len_d;
  logic [PASS_W-1:0]     num_pass_q, num_pass_d;
  logic [c_PTR_W-1:0]    rd_q, rd_d;
  logic [c_PTR_W-1:0]    wr_q, wr_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] scratch_q [ROW_MAX];
  logic [DATA_WIDTH-1:0] fifo_q    [OUT_DEPTH];

  logic                  w_cfg_ok;
  logic                  w_start_ok;
  logic                  w_last_pass;
  logic                  w_last_pos;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_psum_ready;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_acc_val;

  // --------------------------------------------------------------------------
  // Shared decode
  // --------------------------------------------------------------------------
  assign w_cfg_ok     = (cfg_row_len_i != '0) &&
                        (cfg_row_len_i <= c_ROW_W'(ROW_MAX)) &&
                        (cfg_num_pass_i != '0);
  assign w_start_ok   = (state_q == c_ST_IDLE) && start_i && w_cfg_ok;
  assign w_last_pass  = (pass_q == (num_pass_q - PASS_W'(1)));
  assign w_last_pos   = (c_ROW_W'(pos_q) == (row_len_q - c_ROW_W'(1)));
  assign w_fifo_full  = (cnt_q == c_CNT_W'(OUT_DEPTH));
  assign w_fifo_empty = (cnt_q == '0);

  assign w_accept = psum_i.valid && w_psum_ready;
  assign w_push   = w_accept && w_last_pass;
  assign w_pop    = !w_fifo_empty && out_o.ready;

  // Combinational scratchpad read so each accept is a one-cycle RMW.
  // Pass 0 ignores the stale entry, so the scratchpad never needs clearing.
  assign w_sum     = scratch_q[pos_q] + psum_i.data;
  assign w_acc_val = (pass_q == '0) ? psum_i.data : w_sum;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_start_ok) begin
          state_d = c_ST_ACCUM;
        end
      end
      c_ST_ACCUM: begin
        if (w_accept && w_last_pos && w_last_pass) begin
          state_d = c_ST_FLUSH;
        end
      end
      c_ST_FLUSH: begin
        if (w_fifo_empty) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_psum_ready = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      c_ST_ACCUM: begin
        busy_o       = 1'b1;
        // Uses the registered count only, so a same-cycle pop cannot
        // raise ready combinationally.
        w_psum_ready = !(w_last_pass && w_fifo_full);
      end
      c_ST_FLUSH: begin
        busy_o = 1'b1;
        done_o = w_fifo_empty;
      end
      default: ;
    endcase
  end

  assign psum_i.ready = w_psum_ready;

  // --------------------------------------------------------------------------
  // Position / pass counters and latched configuration
  // --------------------------------------------------------------------------
  always_comb begin
    pos_d      = pos_q;
    pass_d     = pass_q;
    row_len_d  = row_len_q;
    num_pass_d = num_pass_q;
    if (w_start_ok) begin
      pos_d      = '0;
      pass_d     = '0;
      row_len_d  = cfg_row_len_i;
      num_pass_d = cfg_num_pass_i;
    end else if (w_accept) begin
      if (w_last_pos) begin
        pos_d  = '0;
        pass_d = pass_q + PASS_W'(1);
      end else begin
        pos_d  = pos_q + c_POS_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    wr_d  = w_push ? (wr_q + c_PTR_W'(1)) : wr_q;
    rd_d  = w_pop  ? (rd_q + c_PTR_W'(1)) : rd_q;
    cnt_d = cnt_q;
    if (w_push && !w_pop) begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end else if (w_pop && !w_push) begin
      cnt_d = cnt_q - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q      <= '0;
      pass_q     <= '0;
      row_len_q  <= '0;
      num_pass_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      pos_q      <= pos_d;
      pass_q     <= pass_d;
      row_len_q  <= row_len_d;
      num_pass_q <= num_pass_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage arrays (no reset: contents are qualified by pointers/pass index)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept && !w_last_pass) begin
      scratch_q[pos_q] <= w_acc_val;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_q] <= w_acc_val;
    end
  end

  assign out_o.valid = !w_fifo_empty;
  assign out_o.data  = fifo_q[rd_q];

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_accum_buffer
// Purpose  : Self-checking bench for psum_accum_buffer. A job-level model
//            (accept index -> pass/position, sums kept in an int array,
//            expected FIFO contents in a queue) is compared against the DUT
//            every cycle; directed jobs also check hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accum_buffer;

  localparam int DW   = 18;
  localparam int RM   = 32;
  localparam int PW   = 8;
  localparam int OD   = 8;
  localparam int RW   = $clog2(RM) + 1;
  localparam int MASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] cfg_rl;
  logic [PW-1:0] cfg_np;
  logic          busy;
  logic          done;

  psum_accum_buffer_if #(.DATA_WIDTH(DW)) psum_if ();
  psum_accum_buffer_if #(.DATA_WIDTH(DW)) out_if ();

  psum_accum_buffer #(
    .DATA_WIDTH(DW),
    .ROW_MAX   (RM),
    .PASS_W    (PW),
    .OUT_DEPTH (OD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .cfg_row_len_i (cfg_rl),
    .cfg_num_pass_i(cfg_np),
    .psum_i        (psum_if),
    .out_o         (out_if),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // ---------------------------------------------------------------- model
  bit          mon_en  = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_flush = 1'b0;
  int          m_rl    = 1;
  int          m_np    = 1;
  int          m_idx   = 0;
  int unsigned m_acc [RM];
  int unsigned m_q [$];
  bit          m_accept = 1'b0;   // model says the coming edge takes psum

  // observations of the DUT, cleared per test
  int          got [$];
  int          done_cnt    = 0;
  int          dut_acc_cnt = 0;

  always @(negedge clk) begin : compare
    bit          e_ready, e_done, acc, pop, last, busy_pre;
    int          pass_i, pos_i;
    int unsigned v;

    if (m_busy && !m_flush)
      e_ready = !(((m_idx / m_rl) == m_np - 1) && (m_q.size() == OD));
    else
      e_ready = 1'b0;
    e_done = m_busy && m_flush && (m_q.size() == 0);

    if (mon_en) begin
      chk("psum_ready", int'(psum_if.ready), int'(e_ready));
      chk("out_valid",  int'(out_if.valid),  int'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_data", int'(out_if.data), longint'(m_q[0]));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(e_done));
    end

    if (psum_if.valid && psum_if.ready) dut_acc_cnt++;
    if (out_if.valid && out_if.ready)   got.push_back(int'(out_if.data));
    if (done)                           done_cnt++;

    // advance the model over the coming clock edge
    busy_pre = m_busy;
    acc      = psum_if.valid && e_ready;
    pop      = (m_q.size() != 0) && out_if.ready;
    m_accept = acc;
    if (rst) begin
      m_busy = 0; m_flush = 0; m_idx = 0; m_accept = 0;
      m_q.delete();
    end else begin
      last = 1'b0;
      v    = 0;
      if (acc) begin
        pass_i = m_idx / m_rl;
        pos_i  = m_idx % m_rl;
        v      = (pass_i == 0) ? int'(psum_if.data)
                               : ((m_acc[pos_i] + int'(psum_if.data)) & MASK);
        last   = (pass_i == m_np - 1);
        if (!last) m_acc[pos_i] = v;
        m_idx++;
        if (m_idx == m_rl * m_np) m_flush = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (acc && last) m_q.push_back(v);
      if (e_done) begin m_busy = 0; m_flush = 0; end
      if (!busy_pre && start && cfg_rl >= 1 && int'(cfg_rl) <= RM && cfg_np != 0) begin
        m_busy = 1; m_flush = 0; m_idx = 0;
        m_rl = int'(cfg_rl); m_np = int'(cfg_np);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got.delete();
    done_cnt    = 0;
    dut_acc_cnt = 0;
  endtask

  task automatic start_job(input int rl, input int np);
    cfg_rl = RW'(rl);
    cfg_np = PW'(np);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic send(input int d);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    psum_if.valid = 1'b1;
    psum_if.data  = DW'(d);
    while (!ok && n < 100) begin
      @(posedge clk);
      ok = m_accept;
      n++;
    end
    #1;
    chk("send_accepted", int'(ok), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || out_if.valid) && n < budget) begin
      step();
      n++;
    end
    step();
    chk({name, "_drained"}, int'(!busy && !out_if.valid), 1);
  endtask

  task automatic chk_got(input string name, input int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk({name, "_value"}, got[i], exp[i]);
    end
  endtask

  // ---------------------------------------------------------------- tests
  initial begin : stim
    int e [$];

    rst           = 1'b1;
    start         = 1'b0;
    cfg_rl        = '0;
    cfg_np        = '0;
    psum_if.valid = 1'b0;
    psum_if.data  = '0;
    out_if.ready  = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_psum_ready", int'(psum_if.ready), 0);
    chk("reset_out_valid",  int'(out_if.valid),  0);
    chk("reset_busy",       int'(busy),          0);
    chk("reset_done",       int'(done),          0);

    // T1: single pass, straight through
    clear_obs();
    start_job(4, 1);
    for (int i = 1; i <= 4; i++) send(i);
    psum_if.valid = 1'b0;
    wait_idle("t1", 50);
    e = '{1, 2, 3, 4};
    chk_got("t1", e);
    chk("t1_done_pulses", done_cnt, 1);

    // T2: three passes accumulate
    clear_obs();
    start_job(3, 3);
    e = '{1, 2, 3, 10, 20, 30, 100, 200, 300};
    foreach (e[i]) send(e[i]);
    psum_if.valid = 1'b0;
    wait_idle("t2", 50);
    e = '{111, 222, 333};
    chk_got("t2", e);
    chk("t2_done_pulses", done_cnt, 1);

    // T3: sum wraps modulo 2^18
    clear_obs();
    start_job(1, 2);
    send(MASK);
    send(2);
    psum_if.valid = 1'b0;
    wait_idle("t3", 50);
    e = '{1};
    chk_got("t3", e);

    // T4: back-pressure stalls input after OUT_DEPTH accepts
    clear_obs();
    out_if.ready = 1'b0;
    start_job(10, 1);
    fork
      begin
        for (int i = 0; i < 10; i++) send(50 + i);
        psum_if.valid = 1'b0;
      end
      begin
        repeat (20) step();
        chk("t4_ready_low", int'(psum_if.ready), 0);
        chk("t4_accepts",   dut_acc_cnt, 8);
        out_if.ready = 1'b1;
      end
    join
    wait_idle("t4", 60);
    e = '{50, 51, 52, 53, 54, 55, 56, 57, 58, 59};
    chk_got("t4", e);
    chk("t4_done_pulses", done_cnt, 1);

    // T5: four queued, then push+pop together; start while busy ignored
    clear_obs();
    out_if.ready = 1'b0;
    start_job(8, 1);
    for (int i = 1; i <= 4; i++) send(i * 7);
    psum_if.valid = 1'b0;
    step();
    start_job(2, 1);
    chk("t5_busy_after_start", int'(busy), 1);
    out_if.ready = 1'b1;
    for (int i = 5; i <= 8; i++) send(i * 7);
    psum_if.valid = 1'b0;
    wait_idle("t5", 50);
    e = '{7, 14, 21, 28, 35, 42, 49, 56};
    chk_got("t5", e);
    chk("t5_done_pulses", done_cnt, 1);

    // T6: reset mid pass 1, then a clean job, then bad configs
    clear_obs();
    start_job(4, 3);
    for (int i = 1; i <= 6; i++) send(i);
    psum_if.valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_psum_ready", int'(psum_if.ready), 0);
    chk("t6_rst_out_valid",  int'(out_if.valid),  0);
    chk("t6_rst_busy",       int'(busy),          0);
    clear_obs();
    start_job(2, 1);
    send(7);
    send(9);
    psum_if.valid = 1'b0;
    wait_idle("t6", 50);
    e = '{7, 9};
    chk_got("t6", e);
    chk("t6_done_pulses", done_cnt, 1);

    clear_obs();
    start_job(0, 1);
    repeat (3) step();
    start_job(33, 1);
    repeat (3) step();
    start_job(4, 0);
    repeat (5) step();
    chk("t6_badcfg_busy", int'(busy), 0);
    chk("t6_badcfg_done", done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
